// File: rtl/port_activity_pkg.sv
// Shared types and helpers for the port activity monitor.
package port_activity_pkg;

    // Measurement phases: waiting for start, sampling the bus, holding a report.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REPORT = 2'd2
    } pam_state_t;

    // Window counter width: clog2 of the window, but never narrower than one bit.
    function automatic int unsigned calc_cnt_w(input int unsigned window);
        if (window <= 1) begin
            return 1;
        end
        return $clog2(window);
    endfunction

endpackage

// File: rtl/activity_toggle_acc.sv
// Per-bus toggle accumulator: remembers the previous sample and ORs in
// every bit that differs from it while enabled.
module activity_toggle_acc #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] acc;

    // acc_next already includes the current cycle's comparison so the
    // caller can capture the final window result on the same edge.
    assign acc_next = acc | (data ^ prev);

    // Clear seeds prev with the current bus value; enable folds in changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            acc  <= '0;
        end else if (clear) begin
            prev <= data;
            acc  <= '0;
        end else if (enable) begin
            prev <= data;
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/port_activity_monitor.sv
// Watches a bus of nominally quiet bits over a fixed window and reports
// which bits toggled and which stayed stuck (with their stuck value).
module port_activity_monitor
    import port_activity_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int WINDOW = 256
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             start,
    input  logic [WIDTH-1:0] I,
    output logic             busy,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [WIDTH-1:0] toggled,
    output logic [WIDTH-1:0] stuck,
    output logic [WIDTH-1:0] stuck_val
);

    localparam int CNT_W = calc_cnt_w(WINDOW);

    pam_state_t       state;
    pam_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             acc_clear;
    logic             acc_en;
    logic             last_sample;
    logic [WIDTH-1:0] acc_next;

    assign last_sample = (state == SAMPLE) && (cnt == '0);

    activity_toggle_acc #(
        .WIDTH (WIDTH)
    ) u_acc (
        .clk      (CLK),
        .rst_n    (ASYNCRESETN),
        .clear    (acc_clear),
        .enable   (acc_en),
        .data     (I),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so nothing queues.
    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clear  = 1'b1;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                acc_en = 1'b1;
                if (cnt == '0) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (report_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window counter: loaded on start, counts down to zero and stops there.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            cnt <= '0;
        end else if (acc_clear) begin
            cnt <= CNT_W'(WINDOW - 1);
        end else if ((state == SAMPLE) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Report registers: written only on the final comparison, held otherwise.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            toggled   <= '0;
            stuck     <= '1;
            stuck_val <= '0;
        end else if (last_sample) begin
            toggled   <= acc_next;
            stuck     <= ~acc_next;
            stuck_val <= I;
        end
    end

    // Status flags registered from the next state so they are glitch-free.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            busy         <= 1'b0;
            report_valid <= 1'b0;
        end else begin
            busy         <= (state_next != IDLE);
            report_valid <= (state_next == REPORT);
        end
    end

endmodule

// File: tb/tb_port_activity_monitor.sv
// Scoreboard bench for port_activity_monitor with WIDTH=2, WINDOW=4.
module tb_port_activity_monitor;

    localparam int WIDTH  = 2;
    localparam int WINDOW = 4;

    typedef struct packed {
        logic [WIDTH-1:0] toggled;
        logic [WIDTH-1:0] stuck;
        logic [WIDTH-1:0] stuckVal;
    } report_t;

    logic             clk;
    logic             rstN;
    logic             start;
    logic [WIDTH-1:0] monIn;
    logic             busy;
    logic             reportValid;
    logic             reportReady;
    logic [WIDTH-1:0] toggled;
    logic [WIDTH-1:0] stuck;
    logic [WIDTH-1:0] stuckVal;

    report_t          sb[$];
    logic [WIDTH-1:0] lastToggled;
    int               checkCount;
    int               failCount;

    port_activity_monitor #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW)
    ) dut (
        .CLK          (clk),
        .ASYNCRESETN  (rstN),
        .start        (start),
        .I            (monIn),
        .busy         (busy),
        .report_valid (reportValid),
        .report_ready (reportReady),
        .toggled      (toggled),
        .stuck        (stuck),
        .stuck_val    (stuckVal)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one window. seq holds the bus value sampled at E0..E4, E0 in the
    // low bits. Called #1 after a rising edge; returns #1 after E_WINDOW.
    task automatic applyStimulus(input logic [2*WIDTH+2*WIDTH*(WINDOW-1)-1:0] seq,
                                 input bit pokeStart);
        report_t          exp;
        logic [WIDTH-1:0] tog;
        start = 1'b1;
        monIn = seq[WIDTH-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 1);
        for (int k = 1; k <= WINDOW; k++) begin
            monIn = seq[WIDTH*k +: WIDTH];
            start = (pokeStart && k == 2);
            @(posedge clk); #1;
            if (k == 1) checkOutput("masks_held_in_sample", 32'(toggled), 32'(lastToggled));
            if (k < WINDOW) checkOutput("valid_early", 32'(reportValid), 0);
            else            checkOutput("valid_latency", 32'(reportValid), 1);
        end
        start = 1'b0;
        monIn = ~seq[WIDTH*WINDOW +: WIDTH];
        tog = '0;
        for (int k = 1; k <= WINDOW; k++) begin
            tog |= seq[WIDTH*k +: WIDTH] ^ seq[WIDTH*(k-1) +: WIDTH];
        end
        exp.toggled  = tog;
        exp.stuck    = ~tog;
        exp.stuckVal = seq[WIDTH*WINDOW +: WIDTH];
        sb.push_back(exp);
    endtask

    // Pops the oldest expected report, compares it, holds ready low for
    // 'hold' cycles checking stability, then completes the handshake.
    task automatic collectReport(input int hold, input bit startDuringHold,
                                 input bit startWithReady);
        report_t exp;
        int      n;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
            return;
        end
        exp = sb.pop_front();
        n = 0;
        while (!reportValid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("valid_seen", 32'(reportValid), 1);
        checkOutput("toggled", 32'(toggled), 32'(exp.toggled));
        checkOutput("stuck", 32'(stuck), 32'(exp.stuck));
        checkOutput("stuck_val", 32'(stuckVal), 32'(exp.stuckVal));
        reportReady = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = startDuringHold;
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(reportValid), 1);
            checkOutput("hold_toggled", 32'(toggled), 32'(exp.toggled));
            checkOutput("hold_stuck_val", 32'(stuckVal), 32'(exp.stuckVal));
        end
        start       = startWithReady;
        reportReady = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        reportReady = 1'b0;
        checkOutput("done_valid", 32'(reportValid), 0);
        checkOutput("done_busy", 32'(busy), 0);
        lastToggled = exp.toggled;
        if (!startWithReady) begin
            @(posedge clk); #1;
            checkOutput("idle_stays_idle", 32'(busy), 0);
        end
    endtask

    // Main sequence.
    initial begin
        checkCount  = 0;
        failCount   = 0;
        lastToggled = '0;
        rstN        = 1'b0;
        start       = 1'b0;
        reportReady = 1'b0;
        monIn       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_valid", 32'(reportValid), 0);
        checkOutput("reset_stuck", 32'(stuck), 32'h3);
        checkOutput("reset_toggled", 32'(toggled), 0);
        checkOutput("reset_stuck_val", 32'(stuckVal), 0);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk); #1;

        // Constant 10 on the bus: nothing toggles.
        applyStimulus(10'b10_10_10_10_10, 1'b0);
        collectReport(0, 1'b0, 1'b0);

        // Bit 0 rises at E2 only.
        applyStimulus(10'b01_01_01_00_00, 1'b0);
        collectReport(0, 1'b0, 1'b0);

        // Both bits toggle; start pokes in SAMPLE and REPORT, long hold.
        applyStimulus(10'b11_11_11_11_00, 1'b1);
        collectReport(10, 1'b1, 1'b0);

        // start together with ready, then back-to-back window that overwrites.
        applyStimulus(10'b10_10_10_10_00, 1'b0);
        collectReport(0, 1'b0, 1'b1);
        applyStimulus(10'b11_10_11_10_11, 1'b0);
        collectReport(0, 1'b0, 1'b0);

        // Reset asserted at E2 of a window discards it.
        start = 1'b1;
        monIn = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        monIn = 2'b01;
        @(posedge clk);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_valid", 32'(reportValid), 0);
        checkOutput("midreset_stuck", 32'(stuck), 32'h3);
        checkOutput("midreset_toggled", 32'(toggled), 0);
        lastToggled = '0;
        @(negedge clk) rstN = 1'b1;
        @(posedge clk); #1;
        applyStimulus(10'b01_00_00_00_00, 1'b0);
        collectReport(0, 1'b0, 1'b0);

        // Change exactly at the last comparison; the later change is ignored.
        applyStimulus(10'b10_00_00_00_00, 1'b0);
        collectReport(2, 1'b0, 1'b0);

        checkOutput("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/port_activity_monitor.md
# port_activity_monitor

Runtime companion to the tie-off cells. It watches a bus of nominally terminated/unused bits over a fixed sampling window and reports which bits toggled and which stayed stuck, with their stuck value. It sits beside a hierarchy's terminated inputs and driven-constant outputs so that simulation and FPGA debug can confirm that "unused" and "undriven" nets are actually quiet. Results are delivered through a valid/ready report handshake.

## Interface
- WIDTH, 2: number of monitored bits; must be ≥ 1.
- WINDOW, 256: number of per-cycle comparisons per measurement; must be ≥ 1.
- CNT_W, max(1, $clog2(WINDOW)): width of the window counter (derived; do not override).

- CLK  in  1  single clock; all state updates on rising edge.
- ASYNCRESETN  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to CLK.
- start  in  1  begin a measurement; honoured only in IDLE.
- I  in  WIDTH  monitored bits.
- busy  out  1  high in SAMPLE and REPORT.
- report_valid  out  1  report available; high only in REPORT.
- report_ready  in  1  consumer accepts report.
- toggled  out  WIDTH  bit k = 1 if I[k] changed at least once during the window.
- stuck  out  WIDTH  equals ~toggled, registered.
- stuck_val  out  WIDTH  value of I at the final window sample; meaningful only where stuck = 1.

## Operation
- States: IDLE, SAMPLE, REPORT.
- IDLE, start = 1: prev ← I, acc ← 0, cnt ← WINDOW−1, go to SAMPLE. start = 0: stay.
- SAMPLE, every edge: acc ← acc | (I ^ prev), prev ← I. If cnt = 0: toggled ← acc | (I ^ prev), stuck ← ~(acc | (I ^ prev)), stuck_val ← I, go to REPORT. Otherwise cnt ← cnt − 1.
- REPORT: report_valid = 1. Outputs hold stable until report_ready = 1 on an edge, then go to IDLE.
- start is ignored in SAMPLE and REPORT, with no queuing. start and report_ready high together in REPORT completes the handshake only; the next start is honoured from IDLE one cycle later.
- toggled, stuck and stuck_val keep their last report values in IDLE and SAMPLE. They are overwritten only on the SAMPLE→REPORT edge.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the decrement occurs only when cnt ≠ 0.
- ASYNCRESETN low at any time, including mid-window or in REPORT, forces:
  - state IDLE;
  - prev, acc, cnt, toggled, stuck_val = 0;
  - stuck = all-ones (no toggle observed);
  - busy = 0, report_valid = 0.
  
  The aborted measurement is discarded.

## Timing
- Let edge E0 be the edge on which start is sampled in IDLE. busy is high from after E0.
- Comparisons occur on edges E1..E_WINDOW, exactly WINDOW of them. report_valid rises after E_WINDOW, a latency of WINDOW cycles from start.
- A transition of I between the values sampled at E0 and E_WINDOW inclusive is detected. A pulse shorter than one cycle that is not sampled is not detected.
- REPORT lasts at least one cycle. With report_ready held high, the minimum start-to-start period is WINDOW+2 cycles.
- All outputs are registered; there are no combinational paths from I, start or report_ready to any output.

## Structure
- Shared package port_activity_pkg:
  - typedef enum pam_state_t {IDLE, SAMPLE, REPORT};
  - function for CNT_W derivation (clog2 with minimum 1).
- Sub-module activity_toggle_acc: one per-bus accumulator holding prev/acc with clear and enable inputs. The top level holds the FSM, counter and report registers.

## Test plan
- WIDTH=2, WINDOW=4, I=2'b10 constant, start pulse: report_valid rises exactly 4 cycles after start; toggled=00, stuck=11, stuck_val=10.
- I[0] toggles once at E2 only, I[1]=0: toggled=01, stuck=10, stuck_val[1]=0.
- report_ready held low for 10 cycles in REPORT: outputs stable, report_valid stays 1. start pulses during SAMPLE and REPORT are ignored, so only one report is produced.
- start and report_ready high together in REPORT: returns to IDLE, busy=0, no new window begins. A start one cycle later begins the next window, and its report overwrites the masks.
- ASYNCRESETN pulsed low at E2 of a window: immediately busy=0, report_valid=0, stuck=11, toggled=00. A following start yields a full fresh 4-cycle window.
- I changes exactly at E4 (the last comparison) only: detected, toggled=bit set. A change after E4 is not reflected in the report.
